carrier_demap: RTL and testbench

- Receive-side counterpart of the transmit subcarrier mapper.
- Consumes the FFT output stream one bin per cycle and reads each bin's 2-bit map code from the per-bandwidth carrier map ROM.
- Routes each bin to a data stream or a pilot stream, or drops it.
- Sits between the RX FFT and the channel estimator / equaliser.

---
 rtl/carrier_demap.sv | 192 +++++++++++++++++++
 tb/tb_carrier_demap.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrier_demap.sv
// rtl/carrier_demap.sv - RX subcarrier demapper: routes FFT bins to data/pilot streams via the carrier map ROM
// Optional: DEMAP_CNT_EN builds per-symbol data/pilot carrier counters (data_cnt/pilot_cnt).
module carrier_demap #(
    parameter int depht_ram = 10,
    parameter int fftsize   = 1024,
    parameter int DW        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           index_bw,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic [DW-1:0]        in_re,
    input  logic [DW-1:0]        in_im,
    output logic [depht_ram-1:0] map_addr,
    output logic [2:0]           map_bw,
    input  logic [1:0]           map_code,
    output logic                 dat_valid,
    output logic [DW-1:0]        dat_re,
    output logic [DW-1:0]        dat_im,
    output logic [depht_ram-1:0] dat_idx,
    output logic                 pil_valid,
    output logic [DW-1:0]        pil_re,
    output logic [DW-1:0]        pil_im,
    output logic [depht_ram-1:0] pil_bin,
    output logic                 sym_done,
    output logic                 err_short,
    output logic                 err_long,
    output logic [depht_ram:0]   data_cnt,
    output logic [depht_ram:0]   pilot_cnt
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [1:0] CODE_DATA  = 2'b01;
    localparam logic [1:0] CODE_PILOT = 2'b10;

    localparam logic [depht_ram-1:0] LAST_BIN = depht_ram'(fftsize - 1);
    localparam logic [depht_ram-1:0] ONE      = depht_ram'(1);

    logic [1:0]           state;
    logic                 flush_cnt;
    logic [depht_ram-1:0] bin_cnt;
    logic [depht_ram-1:0] addr_reg;
    logic [2:0]           bw_reg;
    logic                 acc_sop;
    logic                 acc_bin;
    logic                 acc_any;
    logic [depht_ram-1:0] cur_bin;
    logic                 done_p1;
    logic                 done_p2;

    logic                 s1_valid;
    logic                 s1_sop;
    logic [DW-1:0]        s1_re;
    logic [DW-1:0]        s1_im;
    logic [depht_ram-1:0] s1_bin;
    logic [depht_ram-1:0] dat_ord;
    logic [depht_ram-1:0] ord_base;
    logic                 is_dat;
    logic                 is_pil;

    always_comb begin
        acc_sop  = in_valid && in_sop;
        acc_bin  = in_valid && !in_sop && (state == ST_RUN);
        acc_any  = acc_sop || acc_bin;
        cur_bin  = acc_sop ? '0 : bin_cnt;
        is_dat   = s1_valid && (map_code == CODE_DATA);
        is_pil   = s1_valid && (map_code == CODE_PILOT);
        ord_base = s1_sop ? '0 : dat_ord;
    end

    // The ROM registers its lookup, so address and bandwidth are driven combinationally
    // in the accept cycle; map_code then lines up with stage 1 one cycle later.
    assign map_addr = reset ? '0   : (acc_any ? cur_bin : addr_reg);
    assign map_bw   = reset ? 3'd0 : (acc_sop ? index_bw : bw_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            flush_cnt <= 1'b0;
            bin_cnt   <= '0;
            addr_reg  <= '0;
            bw_reg    <= 3'd0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            done_p1   <= 1'b0;
        end else begin
            err_short <= acc_sop && (state == ST_RUN);
            err_long  <= in_valid && !in_sop && (state == ST_FLUSH);
            done_p1   <= acc_any && (cur_bin == LAST_BIN);
            if (acc_any) begin
                addr_reg <= cur_bin;
                bin_cnt  <= cur_bin + ONE;
            end
            if (acc_sop) begin
                bw_reg <= index_bw;
            end
            if (acc_any) begin
                state     <= (cur_bin == LAST_BIN) ? ST_FLUSH : ST_RUN;
                flush_cnt <= 1'b0;
            end else if (state == ST_FLUSH) begin
                flush_cnt <= 1'b1;
                if (flush_cnt) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_bin   <= '0;
        end else begin
            s1_valid <= acc_any;
            s1_sop   <= acc_sop;
            if (acc_any) begin
                s1_re  <= in_re;
                s1_im  <= in_im;
                s1_bin <= cur_bin;
            end
        end
    end

    // The data ordinal restarts with the sop bin as it passes stage 2, so bins of an
    // aborted symbol still draining ahead of it keep their old numbering.
    always_ff @(posedge clk) begin
        if (reset) begin
            dat_valid <= 1'b0;
            dat_re    <= '0;
            dat_im    <= '0;
            dat_idx   <= '0;
            dat_ord   <= '0;
            pil_valid <= 1'b0;
            pil_re    <= '0;
            pil_im    <= '0;
            pil_bin   <= '0;
            done_p2   <= 1'b0;
            sym_done  <= 1'b0;
        end else begin
            dat_valid <= is_dat;
            pil_valid <= is_pil;
            done_p2   <= done_p1;
            sym_done  <= done_p2;
            if (is_dat) begin
                dat_re  <= s1_re;
                dat_im  <= s1_im;
                dat_idx <= ord_base;
                dat_ord <= ord_base + ONE;
            end else if (s1_valid && s1_sop) begin
                dat_ord <= '0;
            end
            if (is_pil) begin
                pil_re  <= s1_re;
                pil_im  <= s1_im;
                pil_bin <= s1_bin;
            end
        end
    end

`ifdef DEMAP_CNT_EN
    logic [depht_ram:0] acc_dat;
    logic [depht_ram:0] acc_pil;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_dat   <= '0;
            acc_pil   <= '0;
            data_cnt  <= '0;
            pilot_cnt <= '0;
        end else begin
            if (s1_valid) begin
                acc_dat <= (s1_sop ? '0 : acc_dat) + {{depht_ram{1'b0}}, is_dat};
                acc_pil <= (s1_sop ? '0 : acc_pil) + {{depht_ram{1'b0}}, is_pil};
            end
            if (done_p2) begin
                data_cnt  <= acc_dat;
                pilot_cnt <= acc_pil;
            end
        end
    end
`else
    assign data_cnt  = '0;
    assign pilot_cnt = '0;
`endif

endmodule

// File: tb/tb_carrier_demap.sv
// tb/tb_carrier_demap.sv - randomized self-checking bench for carrier_demap against an event-list reference model
module tb_carrier_demap;
    localparam int DR  = 4;
    localparam int FFT = 16;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    index_bw = 3'd0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic [DR-1:0] map_addr;
    logic [2:0]    map_bw;
    logic [1:0]    map_code = 2'b00;
    logic          dat_valid, pil_valid, sym_done, err_short, err_long;
    logic [DW-1:0] dat_re, dat_im, pil_re, pil_im;
    logic [DR-1:0] dat_idx, pil_bin;
    logic [DR:0]   data_cnt, pilot_cnt;

    carrier_demap #(.depht_ram(DR), .fftsize(FFT), .DW(DW)) dut (
        .clk(clk), .reset(reset), .index_bw(index_bw), .in_valid(in_valid), .in_sop(in_sop),
        .in_re(in_re), .in_im(in_im), .map_addr(map_addr), .map_bw(map_bw), .map_code(map_code),
        .dat_valid(dat_valid), .dat_re(dat_re), .dat_im(dat_im), .dat_idx(dat_idx),
        .pil_valid(pil_valid), .pil_re(pil_re), .pil_im(pil_im), .pil_bin(pil_bin),
        .sym_done(sym_done), .err_short(err_short), .err_long(err_long),
        .data_cnt(data_cnt), .pilot_cnt(pilot_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [1:0] rom_code(input logic [2:0] bw, input logic [DR-1:0] a);
        if (a == 0 || a == FFT - 1) return 2'b00;
        if (a == 8) return 2'b11;
        if (a == 3 || a == 12) return 2'b10;
        if (bw == 3'd4 && a == 5) return 2'b10;
        return 2'b01;
    endfunction

    always @(posedge clk) map_code <= rom_code(map_bw, map_addr);

    // Event word: kind (1 data, 2 pilot, 3 sym_done, 4 err_short, 5 err_long), cycle, re, im, index
    function automatic logic [63:0] ev(input int kind, input int c, input logic [15:0] re,
                                       input logic [15:0] im, input int idx);
        return {4'(kind), 20'(c), re, im, 8'(idx)};
    endfunction

    logic [63:0] obs[$];
    logic [63:0] exp_q[$];

    always @(negedge clk) begin
        if (dat_valid === 1'b1) obs.push_back(ev(1, cyc, dat_re, dat_im, int'(dat_idx)));
        if (pil_valid === 1'b1) obs.push_back(ev(2, cyc, pil_re, pil_im, int'(pil_bin)));
        if (sym_done === 1'b1)  obs.push_back(ev(3, cyc, 16'(data_cnt), 16'(pilot_cnt), 0));
        if (err_short === 1'b1) obs.push_back(ev(4, cyc, 16'd0, 16'd0, 0));
        if (err_long === 1'b1)  obs.push_back(ev(5, cyc, 16'd0, 16'd0, 0));
    end

    bit         m_run = 0;
    int         m_n = 0, m_flush = 0, m_ord = 0, m_dc = 0, m_pc = 0;
    logic [2:0] m_bw = 3'd0;

    // Drive one cycle and predict what it should cause, in terms of symbols and bin counts.
    task automatic step(input bit v, input bit s, input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic [2:0] bw);
        bit fl;
        int k;
        logic [1:0] code;
        @(posedge clk); #1;
        in_valid = v; in_sop = s; in_re = re; in_im = im; index_bw = bw;
        k = int'(cyc);
        fl = (m_flush > 0);
        if (m_flush > 0) m_flush--;
        if (v && s) begin
            if (m_run) exp_q.push_back(ev(4, k + 1, 16'd0, 16'd0, 0));
            m_run = 1; m_n = 0; m_bw = bw; m_ord = 0; m_dc = 0; m_pc = 0;
        end else if (v && !m_run && fl) begin
            exp_q.push_back(ev(5, k + 1, 16'd0, 16'd0, 0));
        end
        if (v && m_run) begin
            code = rom_code(m_bw, DR'(m_n));
            if (code == 2'b01) begin
                exp_q.push_back(ev(1, k + 2, re, im, m_ord));
                m_ord++; m_dc++;
            end else if (code == 2'b10) begin
                exp_q.push_back(ev(2, k + 2, re, im, m_n));
                m_pc++;
            end
            m_n++;
            if (m_n == FFT) begin
                m_run = 0; m_flush = 2;
`ifdef DEMAP_CNT_EN
                exp_q.push_back(ev(3, k + 3, 16'(m_dc), 16'(m_pc), 0));
`else
                exp_q.push_back(ev(3, k + 3, 16'd0, 16'd0, 0));
`endif
            end
        end
    endtask

    task automatic idle(input int n, input logic [2:0] bw);
        for (int i = 0; i < n; i++) step(0, 0, 16'($urandom), 16'($urandom), bw);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dat_valid, pil_valid, sym_done, err_short, err_long} !== 5'b0) begin
            errors++; $display("FAIL reset_valids: got %b, expected 00000",
                               {dat_valid, pil_valid, sym_done, err_short, err_long});
        end
        checks++;
        if ({map_addr, map_bw} !== '0) begin
            errors++; $display("FAIL reset_map: got addr %0d bw %0d, expected 0 0", map_addr, map_bw);
        end
        checks++;
        if ({dat_re, dat_im, dat_idx, pil_re, pil_im, pil_bin} !== '0) begin
            errors++; $display("FAIL reset_data: got %h, expected 0",
                               {dat_re, dat_im, dat_idx, pil_re, pil_im, pil_bin});
        end
        checks++;
        if ({data_cnt, pilot_cnt} !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d %0d, expected 0 0", data_cnt, pilot_cnt);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_contiguous;
        int nd, np;
        obs.delete(); exp_q.delete();
        for (int b = 0; b < FFT; b++) step(1, b == 0, 16'(b), 16'(-b), 3'd2);
        idle(6, 3'd2);
        nd = 0; np = 0;
        foreach (obs[i]) begin
            if (obs[i][63:60] == 4'd1) nd++;
            if (obs[i][63:60] == 4'd2) np++;
        end
        checks++;
        if (nd != 11 || np != 2) begin
            errors++; $display("FAIL contig_totals: got %0d data %0d pilots, expected 11 data 2 pilots", nd, np);
        end
        exp_q.sort(); obs.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL contig_count: got %0d events, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++; $display("FAIL contig_event[%0d]: got %h, expected %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_gaps;
        obs.delete(); exp_q.delete();
        for (int b = 0; b < FFT; b++) begin
            step(1, b == 0, 16'($urandom), 16'($urandom), 3'd2);
            step(0, 0, 16'($urandom), 16'($urandom), 3'd2);
        end
        idle(6, 3'd2);
        exp_q.sort(); obs.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL gaps_count: got %0d events, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++; $display("FAIL gaps_event[%0d]: got %h, expected %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_short;
        obs.delete(); exp_q.delete();
        for (int b = 0; b < 9; b++) step(1, b == 0, 16'($urandom), 16'($urandom), 3'd2);
        for (int b = 0; b < FFT; b++) step(1, b == 0, 16'($urandom), 16'($urandom), 3'd2);
        idle(6, 3'd2);
        exp_q.sort(); obs.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL short_count: got %0d events, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++; $display("FAIL short_event[%0d]: got %h, expected %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_long;
        obs.delete(); exp_q.delete();
        for (int b = 0; b < FFT + 1; b++) step(1, b == 0, 16'($urandom), 16'($urandom), 3'd2);
        idle(6, 3'd2);
        exp_q.sort(); obs.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL long_count: got %0d events, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++; $display("FAIL long_event[%0d]: got %h, expected %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_bw_change;
        obs.delete(); exp_q.delete();
        for (int b = 0; b < FFT; b++) begin
            step(1, b == 0, 16'($urandom), 16'($urandom), (b < 7) ? 3'd2 : 3'd4);
            #1;
            if (b == 7 || b == 15) begin
                checks++;
                if (map_bw !== 3'd2) begin
                    errors++; $display("FAIL bw_hold_bin%0d: got %0d, expected 2", b, map_bw);
                end
            end
        end
        for (int b = 0; b < FFT; b++) begin
            step(1, b == 0, 16'($urandom), 16'($urandom), 3'd4);
            #1;
            if (b == 0 || b == 5) begin
                checks++;
                if (map_bw !== 3'd4) begin
                    errors++; $display("FAIL bw_new_bin%0d: got %0d, expected 4", b, map_bw);
                end
            end
        end
        idle(6, 3'd4);
        exp_q.sort(); obs.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL bw_count: got %0d events, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++; $display("FAIL bw_event[%0d]: got %h, expected %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int k;
        logic [63:0] keep[$];
        obs.delete(); exp_q.delete();
        for (int b = 0; b < 6; b++) step(1, b == 0, 16'($urandom), 16'($urandom), 3'd2);
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b1; in_sop = 1'b0; in_re = 16'd6; in_im = 16'hfffa;
        k = int'(cyc);
        foreach (exp_q[i]) if (exp_q[i][59:40] < 20'(k + 1)) keep.push_back(exp_q[i]);
        exp_q = keep;
        m_run = 0; m_flush = 0;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({dat_valid, pil_valid, sym_done, err_short, err_long} !== 5'b0) begin
            errors++; $display("FAIL rstmid_valids: got %b, expected 00000",
                               {dat_valid, pil_valid, sym_done, err_short, err_long});
        end
        checks++;
        if ({map_addr, map_bw, dat_re, dat_im, dat_idx, pil_re, pil_im, pil_bin} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got %h, expected 0",
                               {map_addr, map_bw, dat_re, dat_im, dat_idx, pil_re, pil_im, pil_bin});
        end
        for (int b = 0; b < FFT; b++) step(1, b == 0, 16'($urandom), 16'($urandom), 3'd2);
        idle(6, 3'd2);
        exp_q.sort(); obs.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL rstmid_count: got %0d events, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rstmid_event[%0d]: got %h, expected %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] bw;
        obs.delete(); exp_q.delete();
        for (int s = 0; s < 4; s++) begin
            bw = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd4;
            for (int b = 0; b < FFT; b++) begin
                step(1, b == 0, 16'($urandom), 16'($urandom), bw);
                if ($urandom_range(0, 3) == 0) step(0, 0, 16'($urandom), 16'($urandom), bw);
            end
            for (int g = $urandom_range(0, 3); g > 0; g--)
                step($urandom_range(0, 1) == 1, 0, 16'($urandom), 16'($urandom), bw);
        end
        idle(6, 3'd2);
        exp_q.sort(); obs.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d events, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++; $display("FAIL b2b_event[%0d]: got %h, expected %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_gaps();
        test_short();
        test_long();
        test_bw_change();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
